// File: rtl/lcd_instr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_instr_arbiter
//  Description : Round-robin sharing of one LCD instruction transmitter
//                between the configure/refresh FSM (port 0) and the user
//                text/cursor writer (port 1). Supports locked bursts and a
//                watchdog that aborts commands whose done never arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_instr_arbiter #(
    parameter int DB_WIDTH       = 10,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_WIDTH      = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic                lock0,
    input  logic                lock1,
    input  logic [DB_WIDTH-1:0] db0,
    input  logic [DB_WIDTH-1:0] db1,
    output logic                grant0,
    output logic                grant1,
    output logic                done0,
    output logic                done1,
    output logic                abort,
    output logic                next_instruction,
    output logic [DB_WIDTH-1:0] db,
    input  logic                done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } state_t;

    // Watchdog value seen in the last cycle before the abort is raised.
    localparam logic [CNT_WIDTH-1:0] C_WDOG_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  rr_last_q, rr_last_d;
    logic [CNT_WIDTH-1:0]  wdog_q, wdog_d;
    logic                  mask_q, mask_d;
    logic                  grant0_q, grant0_d;
    logic                  grant1_q, grant1_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;
    logic                  abort_q, abort_d;
    logic                  ni_q, ni_d;
    logic [DB_WIDTH-1:0]   db_q, db_d;

    // Arbitration winner in IDLE: with both requesting, the one not served last.
    logic                  w_win;
    logic                  w_owner_req;
    logic                  w_owner_lock;
    logic [DB_WIDTH-1:0]   w_owner_db;

    assign w_win        = (req0 && req1) ? ~rr_last_q : req1;
    assign w_owner_req  = owner_q ? req1  : req0;
    assign w_owner_lock = owner_q ? lock1 : lock0;
    assign w_owner_db   = owner_q ? db1   : db0;

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        wdog_d    = wdog_q;
        mask_d    = 1'b0;
        grant0_d  = grant0_q;
        grant1_d  = grant1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        abort_d   = 1'b0;
        ni_d      = 1'b0;
        db_d      = db_q;

        case (state_q)
            IDLE: begin
                if (!mask_q) begin
                    if (req0 || req1) begin
                        owner_d  = w_win;
                        db_d     = w_win ? db1 : db0;
                        grant0_d = ~w_win;
                        grant1_d = w_win;
                        // Start pulse is registered, so it is raised on entry to ISSUE.
                        ni_d     = 1'b1;
                        wdog_d   = '0;
                        state_d  = ISSUE;
                    end else begin
                        db_d = '0;
                    end
                end
            end

            ISSUE: begin
                // Watchdog counts cycles elapsed since the start pulse.
                wdog_d  = wdog_q + 1'b1;
                state_d = WAIT_DONE;
            end

            WAIT_DONE: begin
                wdog_d = wdog_q + 1'b1;
                if (done) begin
                    // A done landing on the final watchdog cycle wins over the abort.
                    done0_d   = ~owner_q;
                    done1_d   = owner_q;
                    rr_last_d = owner_q;
                    mask_d    = 1'b1;
                    if (w_owner_lock) begin
                        db_d    = '0;
                        state_d = HOLD;
                    end else begin
                        grant0_d = 1'b0;
                        grant1_d = 1'b0;
                        state_d  = IDLE;
                    end
                end else if (wdog_q == C_WDOG_LAST) begin
                    done0_d   = ~owner_q;
                    done1_d   = owner_q;
                    abort_d   = 1'b1;
                    rr_last_d = owner_q;
                    mask_d    = 1'b1;
                    grant0_d  = 1'b0;
                    grant1_d  = 1'b0;
                    state_d   = IDLE;
                end
            end

            HOLD: begin
                if (!mask_q) begin
                    if (w_owner_req) begin
                        db_d    = w_owner_db;
                        ni_d    = 1'b1;
                        wdog_d  = '0;
                        state_d = ISSUE;
                    end else if (!w_owner_lock) begin
                        grant0_d = 1'b0;
                        grant1_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            wdog_q    <= '0;
            mask_q    <= 1'b0;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            abort_q   <= 1'b0;
            ni_q      <= 1'b0;
            db_q      <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            wdog_q    <= wdog_d;
            mask_q    <= mask_d;
            grant0_q  <= grant0_d;
            grant1_q  <= grant1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            abort_q   <= abort_d;
            ni_q      <= ni_d;
            db_q      <= db_d;
        end
    end

    assign grant0           = grant0_q;
    assign grant1           = grant1_q;
    assign done0            = done0_q;
    assign done1            = done1_q;
    assign abort            = abort_q;
    assign next_instruction = ni_q;
    assign db               = db_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_instr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_lcd_instr_arbiter
//  Description : Self-checking bench for lcd_instr_arbiter; a transaction
//                level round-robin model predicts grant order and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_instr_arbiter;

    localparam int DBW = 10;
    localparam int TO  = 40;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0, req1, lock0, lock1;
    logic [DBW-1:0] db0, db1;
    logic           done;
    logic           grant0, grant1, done0, done1, abort, next_instruction;
    logic [DBW-1:0] db;

    int vectors     = 0;
    int miscompares = 0;
    int model_rr    = 1;   // port served most recently (1 after reset)

    lcd_instr_arbiter #(
        .DB_WIDTH      (DBW),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (17)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req0            (req0),
        .req1            (req1),
        .lock0           (lock0),
        .lock1           (lock1),
        .db0             (db0),
        .db1             (db1),
        .grant0          (grant0),
        .grant1          (grant1),
        .done0           (done0),
        .done1           (done1),
        .abort           (abort),
        .next_instruction(next_instruction),
        .db              (db),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        db0 = '0; db1 = '0; done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        model_rr = 1;
    endtask

    // Ticks until next_instruction is seen; n = ticks taken, -1 on expiry.
    task automatic wait_ni(input int limit, output int n);
        n = 0;
        while (next_instruction !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (next_instruction !== 1'b1) n = -1;
    endtask

    // Ticks until a done0/done1 pulse is seen; n = ticks taken, -1 on expiry.
    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        while (done0 !== 1'b1 && done1 !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (done0 !== 1'b1 && done1 !== 1'b1) n = -1;
    endtask

    // Transmitter model: called on the start-pulse cycle, returns done 'dly'
    // cycles later and reports what the arbiter showed one cycle after that.
    task automatic respond(input int dly, output int stable,
                           output logic o_d0, output logic o_d1, output logic o_ab,
                           output logic o_g0, output logic o_g1);
        logic [DBW-1:0] held;
        held   = db;
        stable = 1;
        for (int i = 0; i < dly; i++) begin
            tick();
            if (db !== held || done0 || done1 || next_instruction) stable = 0;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        o_d0 = done0; o_d1 = done1; o_ab = abort; o_g0 = grant0; o_g1 = grant1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1; lock1 = 1'b1;
        db0 = 10'h155; db1 = 10'h2AA; done = 1'b1;
        tick(); tick();
        vectors++;
        if ({grant0, grant1, done0, done1, abort, next_instruction, db} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_held: outputs=%h required=0000",
                     {grant0, grant1, done0, done1, abort, next_instruction, db});
        end
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; done = 1'b0;
        reset = 1'b0;
        tick();
        vectors++;
        if ({grant0, grant1, done0, done1, abort, next_instruction, db} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_release: outputs=%h required=0000",
                     {grant0, grant1, done0, done1, abort, next_instruction, db});
        end
        model_rr = 1;
    endtask

    task automatic test_single();
        int n, stable;
        logic d0, d1, ab, g0, g1;
        db0 = 10'h028; req0 = 1'b1;
        wait_ni(6, n);
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL single_ni_latency: got %0d cycles, required 1", n);
        end
        vectors++;
        if (grant0 !== 1'b1 || grant1 !== 1'b0 || db !== 10'h028) begin
            miscompares++;
            $display("FAIL single_grant_db: grant0=%b grant1=%b db=%h, required 1 0 028",
                     grant0, grant1, db);
        end
        respond(5, stable, d0, d1, ab, g0, g1);
        vectors++;
        if (stable != 1) begin
            miscompares++;
            $display("FAIL single_db_held: stable=%0d required 1", stable);
        end
        vectors++;
        if ({d0, d1, ab, g0, g1} !== 5'b10000) begin
            miscompares++;
            $display("FAIL single_done: {d0,d1,abort,g0,g1}=%b required 10000", {d0, d1, ab, g0, g1});
        end
        req0 = 1'b0;
        model_rr = 0;
        tick();
    endtask

    // Request patterns (bit0=req0, bit1=req1); winners predicted from round-robin rules.
    task automatic test_arbitration(input int iters, input bit directed);
        int pats [3] = '{3, 1, 3};
        int pat, first, port, n, stable, nserve;
        logic [DBW-1:0] cmd [2];
        logic [1:0] expg;
        logic d0, d1, ab, g0, g1;
        if (directed) do_reset();
        for (int it = 0; it < iters; it++) begin
            pat = directed ? pats[it % 3] : int'($urandom_range(1, 3));
            if (!directed && $urandom_range(0, 3) == 0) begin
                done = 1'b1;
                tick();
                done = 1'b0;
                vectors++;
                if (done0 !== 1'b0 || done1 !== 1'b0 || next_instruction !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stray_done: done0=%b done1=%b ni=%b, required 0 0 0",
                             done0, done1, next_instruction);
                end
            end
            cmd[0] = DBW'($urandom);
            cmd[1] = DBW'($urandom);
            db0 = cmd[0]; db1 = cmd[1];
            req0 = pat[0]; req1 = pat[1];
            first  = (pat == 3) ? 1 - model_rr : ((pat == 2) ? 1 : 0);
            nserve = (pat == 3) ? 2 : 1;
            for (int k = 0; k < nserve; k++) begin
                port = (k == 0) ? first : 1 - first;
                expg = (port == 0) ? 2'b10 : 2'b01;
                wait_ni(6, n);
                vectors++;
                if (n != ((k == 0) ? 1 : 2)) begin
                    miscompares++;
                    $display("FAIL arb_ni_latency: it=%0d k=%0d got %0d cycles, required %0d",
                             it, k, n, (k == 0) ? 1 : 2);
                end
                vectors++;
                if ({grant0, grant1} !== expg || db !== cmd[port]) begin
                    miscompares++;
                    $display("FAIL arb_grant: it=%0d grants=%b db=%h, required %b %h",
                             it, {grant0, grant1}, db, expg, cmd[port]);
                end
                // Dropping req mid-command must not cancel it.
                if (!directed && $urandom_range(0, 3) == 0) begin
                    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
                end
                respond(int'($urandom_range(1, 8)), stable, d0, d1, ab, g0, g1);
                vectors++;
                if (stable != 1 || {d0, d1, ab, g0, g1} !== {expg, 3'b000}) begin
                    miscompares++;
                    $display("FAIL arb_done: it=%0d stable=%0d {d0,d1,abort,g0,g1}=%b, required 1 %b",
                             it, stable, {d0, d1, ab, g0, g1}, {expg, 3'b000});
                end
                if (port == 0) req0 = 1'b0; else req1 = 1'b0;
                model_rr = port;
            end
            tick();
        end
    endtask

    task automatic test_lock_burst();
        int n, stable;
        logic d0, d1, ab, g0, g1;
        logic [DBW-1:0] exp_db, other;
        other = DBW'($urandom);
        lock1 = 1'b1; req1 = 1'b1; db1 = 10'h080;
        exp_db = 10'h080;
        wait_ni(6, n);
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL lock_first_ni: got %0d cycles, required 1", n);
        end
        req0 = 1'b1; db0 = other;
        for (int i = 0; i <= 16; i++) begin
            vectors++;
            if (grant1 !== 1'b1 || grant0 !== 1'b0 || db !== exp_db) begin
                miscompares++;
                $display("FAIL lock_grant: cmd %0d grants=%b db=%h, required 01 %h",
                         i, {grant0, grant1}, db, exp_db);
            end
            respond(int'($urandom_range(1, 6)), stable, d0, d1, ab, g0, g1);
            vectors++;
            if (stable != 1 || {d0, d1, ab, g0, g1} !== 5'b01001 || db !== '0) begin
                miscompares++;
                $display("FAIL lock_done: cmd %0d stable=%0d {d0,d1,abort,g0,g1}=%b db=%h, required 1 01001 000",
                         i, stable, {d0, d1, ab, g0, g1}, db);
            end
            if (i < 16) begin
                exp_db = {2'b10, 8'(8'h41 + i)};
                db1 = exp_db;
                wait_ni(6, n);
                vectors++;
                if (n != 2) begin
                    miscompares++;
                    $display("FAIL lock_spacing: cmd %0d got %0d cycles, required 2", i + 1, n);
                end
            end else begin
                req1 = 1'b0; lock1 = 1'b0;
                model_rr = 1;
            end
        end
        wait_ni(8, n);
        vectors++;
        if (n != 3 || grant0 !== 1'b1 || grant1 !== 1'b0 || db !== other) begin
            miscompares++;
            $display("FAIL lock_release: n=%0d grants=%b db=%h, required 3 10 %h",
                     n, {grant0, grant1}, db, other);
        end
        respond(3, stable, d0, d1, ab, g0, g1);
        vectors++;
        if ({d0, d1, ab, g0, g1} !== 5'b10000) begin
            miscompares++;
            $display("FAIL lock_port0_done: {d0,d1,abort,g0,g1}=%b required 10000", {d0, d1, ab, g0, g1});
        end
        req0 = 1'b0;
        model_rr = 0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        lock0 = 1'b1; req0 = 1'b1; db0 = DBW'($urandom);
        wait_ni(6, n);
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL timeout_ni: got %0d cycles, required 1", n);
        end
        wait_pulse(TO + 10, n);
        vectors++;
        if (n != TO) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d cycles, required %0d", n, TO);
        end
        vectors++;
        if ({done0, done1, abort, grant0, grant1} !== 5'b10100) begin
            miscompares++;
            $display("FAIL timeout_abort: {d0,d1,abort,g0,g1}=%b required 10100",
                     {done0, done1, abort, grant0, grant1});
        end
        req0 = 1'b0; lock0 = 1'b0;
        model_rr = 0;
        tick();
        vectors++;
        if ({done0, done1, abort, grant0, grant1} !== 5'b00000) begin
            miscompares++;
            $display("FAIL timeout_pulse_width: {d0,d1,abort,g0,g1}=%b required 00000",
                     {done0, done1, abort, grant0, grant1});
        end
    endtask

    task automatic test_done_at_timeout();
        int n;
        bit early;
        req1 = 1'b1; db1 = DBW'($urandom);
        wait_ni(6, n);
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL edge_ni: got %0d cycles, required 1", n);
        end
        early = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (done0 || done1 || abort) early = 1'b1;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        vectors++;
        if (early || {done0, done1, abort} !== 3'b010) begin
            miscompares++;
            $display("FAIL edge_done_wins: early=%0d {d0,d1,abort}=%b, required 0 010",
                     early, {done0, done1, abort});
        end
        req1 = 1'b0;
        model_rr = 1;
        tick();
    endtask

    task automatic test_reset_mid();
        int n, stable;
        logic d0, d1, ab, g0, g1;
        logic [DBW-1:0] cmd;
        req0 = 1'b1; db0 = DBW'($urandom);
        wait_ni(6, n);
        tick(); tick(); tick();
        vectors++;
        if (grant0 !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre: grant0=%b required 1", grant0);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({grant0, grant1, done0, done1, abort, next_instruction, db} !== 16'h0) begin
            miscompares++;
            $display("FAIL midreset_async: outputs=%h required=0000",
                     {grant0, grant1, done0, done1, abort, next_instruction, db});
        end
        tick();
        req0 = 1'b0;
        reset = 1'b0;
        model_rr = 1;
        cmd = DBW'($urandom);
        req1 = 1'b1; db1 = cmd;
        wait_ni(6, n);
        vectors++;
        if (n != 1 || grant1 !== 1'b1 || grant0 !== 1'b0 || db !== cmd) begin
            miscompares++;
            $display("FAIL midreset_regrant: n=%0d grants=%b db=%h, required 1 01 %h",
                     n, {grant0, grant1}, db, cmd);
        end
        respond(4, stable, d0, d1, ab, g0, g1);
        vectors++;
        if ({d0, d1, ab, g0, g1} !== 5'b01000) begin
            miscompares++;
            $display("FAIL midreset_done: {d0,d1,abort,g0,g1}=%b required 01000", {d0, d1, ab, g0, g1});
        end
        req1 = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        db0 = '0; db1 = '0; done = 1'b0;
        test_reset();
        test_single();
        test_arbitration(3, 1'b1);
        test_arbitration(40, 1'b0);
        test_lock_burst();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global bound so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "bench time budget exceeded");
    end

endmodule
`default_nettype wire
